pet_uart_keyq: RTL and testbench
================================

// Module: pet_uart_keyq
//
// PURPOSE
//  Parametrised successor to the single-character UART key injector. Accepts ASCII bytes from
//  the UART receiver into a FIFO and replays them one at a time as PET 2001 matrix key presses.
//  Each press is held for a programmable number of full keyboard scans, then released for a gap.
//  Drives the active-low column bus (keyin) for whichever row the PIA is currently scanning.
//
// PARAMETERS
//  FIFO_AW     3   log2 FIFO depth (default 8 entries)
//  HOLD_SCANS  3   full scans (row-0 entries) a key stays pressed; range 1..15
//  GAP_SCANS   2   full scans all keys are released after a press; range 1..15
//  NUM_ROWS    10  rows scanned; keyrow >= NUM_ROWS selects no row
//
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high
//  keyrow       in   4           row currently driven by the PET
//  keyin        out  8           column sense for keyrow, active low
//  uart_data    in   8           received ASCII byte
//  uart_strobe  in   1           one-cycle pulse; uart_data is valid
//  fifo_count   out  FIFO_AW+1   entries queued, excluding the key in progress
//  fifo_full    out  1           fifo_count == 2**FIFO_AW
//  overflow     out  1           one-cycle pulse: a byte was dropped because the FIFO was full
//
// BEHAVIOUR
//  Reset: keyin=8'hFF, fifo_count=0, fifo_full=0, overflow=0, FSM=IDLE, scan counter=0.
//         Applies in every state. A key held mid-press is released on the cycle after reset.
//  Scan tick: keyrow is registered. A tick is one cycle where keyrow_q!=0 and keyrow==0.
//  FIFO
//   - Push on uart_strobe.
//   - Push while full with no pop in the same cycle: byte dropped, overflow=1 for that cycle.
//   - Push and pop in the same cycle while full: both take effect; no overflow.
//   - Pointers wrap modulo 2**FIFO_AW.
//  Decode (combinational, on the FIFO head): returns {valid, shift, row[3:0], col[2:0]}.
//   - Standard PET 2001 graphics-keyboard matrix.
//   - Fixed entries: 0x0D -> row 6, col 5; 0x41 'A' -> row 4, col 0; left shift = row 8, col 0.
//   - Unmapped codes: valid=0.
//  FSM
//   - IDLE: if FIFO is non-empty, pop. valid=1 -> latch row/col/shift, go to PRESS.
//           valid=0 -> drop the byte, stay in IDLE. One pop per cycle at most.
//   - PRESS: count ticks. At the HOLD_SCANS-th tick -> GAP, counter cleared.
//   - GAP: keys released. At the GAP_SCANS-th tick -> IDLE.
//  keyin (registered, 1-cycle latency from keyrow)
//   - 8'hFF by default.
//   - In PRESS with keyrow==row: bit col cleared.
//   - In PRESS with shift=1 and keyrow==8: bit 0 cleared.
//   - If row==8 and shift=1, both clears combine on the same row.
//  The first tick after entering PRESS counts, so a press can be shorter than one full scan by
//  up to one partial scan. The PET debounce is tolerant of this.
//
// CONFIGURATION
//  PET_KEYQ_SHIFT_EN defined:
//   - 0x61-0x7A press the matching letter key with shift=1 (left shift held alongside).
//  PET_KEYQ_SHIFT_EN undefined:
//   - 0x61-0x7A fold to 0x41-0x5A, shift=0.
//   - No decode entry ever sets shift; the shift-row logic is removed.
//
// TESTING  (bench: keyrow steps 0..9, 21 clocks per row; FIFO_AW=3, HOLD=3, GAP=2)
//  1. Strobe 0x0D -> keyin==8'hDF whenever keyrow==6 for 3 scans, else 8'hFF;
//     then 2 scans of all 8'hFF, then FSM is IDLE.
//  2. Strobe 0x41 -> keyin==8'hFE on row 4 only; all other rows read 8'hFF.
//  3. 10 strobes on consecutive cycles -> first byte popped; next 8 queued (fifo_full=1);
//     10th byte gives a one-cycle overflow pulse; the 9 accepted keys replay in order.
//  4. Strobe 0x61 -> with macro: row 4 = 8'hFE and row 8 = 8'hFE during PRESS;
//     without macro: row 4 = 8'hFE only.
//  5. Strobe 0x01 then 0x41 -> 0x01 dropped with no keyin activity; 'A' press starts
//     within 2 cycles of the pop.
//  6. Assert reset during PRESS of 0x0D -> keyin=8'hFF and fifo_count=0 the next cycle;
//     no press resumes after reset is released.

Source files
------------

// File: rtl/pet_uart_keyq.sv
// pet_uart_keyq: queues ASCII bytes from the UART receiver and replays them as
// timed PET 2001 matrix key presses on the active-low column bus.
// Optional feature macro: PET_KEYQ_SHIFT_EN (lower-case letters press with left shift).
module pet_uart_keyq #(
    parameter int FIFO_AW    = 3,
    parameter int HOLD_SCANS = 3,
    parameter int GAP_SCANS  = 2,
    parameter int NUM_ROWS   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       keyrow,
    output logic [7:0]       keyin,
    input  logic [7:0]       uart_data,
    input  logic             uart_strobe,
    output logic [FIFO_AW:0] fifo_count,
    output logic             fifo_full,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [3:0]       HOLD_LAST  = 4'(HOLD_SCANS - 1);
    localparam logic [3:0]       GAP_LAST   = 4'(GAP_SCANS - 1);
    localparam logic [4:0]       ROW_LIMIT  = 5'(NUM_ROWS);

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [7:0]         head;
    logic [7:0]         head_char;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               load;
    logic               tick;
    logic [3:0]         keyrow_q;
    state_t             state;
    state_t             state_n;
    logic [3:0]         scan_cnt;
    logic [3:0]         scan_cnt_n;
    logic               head_valid;
    logic [3:0]         head_row;
    logic [2:0]         head_col;
    logic [3:0]         key_row;
    logic [2:0]         key_col;
    logic [7:0]         keyin_n;
`ifdef PET_KEYQ_SHIFT_EN
    logic               head_shift;
    logic               key_shift;
`endif

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign push       = uart_strobe && (!fifo_full || pop);
    assign tick       = (keyrow_q != 4'd0) && (keyrow == 4'd0);

    // Map the FIFO head byte onto its PET graphics-keyboard matrix position.
    always_comb begin
        head_char  = head;
        head_valid = 1'b1;
        head_row   = 4'd0;
        head_col   = 3'd0;
        if (head >= 8'h61 && head <= 8'h7A) begin
            head_char = head - 8'h20;
        end
`ifdef PET_KEYQ_SHIFT_EN
        head_shift = (head >= 8'h61 && head <= 8'h7A);
`endif
        case (head_char)
            8'h21: {head_row, head_col} = {4'd0, 3'd0};
            8'h23: {head_row, head_col} = {4'd0, 3'd1};
            8'h25: {head_row, head_col} = {4'd0, 3'd2};
            8'h26: {head_row, head_col} = {4'd0, 3'd3};
            8'h28: {head_row, head_col} = {4'd0, 3'd4};
            8'h22: {head_row, head_col} = {4'd1, 3'd0};
            8'h24: {head_row, head_col} = {4'd1, 3'd1};
            8'h27: {head_row, head_col} = {4'd1, 3'd2};
            8'h5C: {head_row, head_col} = {4'd1, 3'd3};
            8'h29: {head_row, head_col} = {4'd1, 3'd4};
            8'h51: {head_row, head_col} = {4'd2, 3'd0};
            8'h45: {head_row, head_col} = {4'd2, 3'd1};
            8'h54: {head_row, head_col} = {4'd2, 3'd2};
            8'h55: {head_row, head_col} = {4'd2, 3'd3};
            8'h4F: {head_row, head_col} = {4'd2, 3'd4};
            8'h37: {head_row, head_col} = {4'd2, 3'd6};
            8'h39: {head_row, head_col} = {4'd2, 3'd7};
            8'h57: {head_row, head_col} = {4'd3, 3'd0};
            8'h52: {head_row, head_col} = {4'd3, 3'd1};
            8'h59: {head_row, head_col} = {4'd3, 3'd2};
            8'h49: {head_row, head_col} = {4'd3, 3'd3};
            8'h50: {head_row, head_col} = {4'd3, 3'd4};
            8'h38: {head_row, head_col} = {4'd3, 3'd6};
            8'h2F: {head_row, head_col} = {4'd3, 3'd7};
            8'h41: {head_row, head_col} = {4'd4, 3'd0};
            8'h44: {head_row, head_col} = {4'd4, 3'd1};
            8'h47: {head_row, head_col} = {4'd4, 3'd2};
            8'h4A: {head_row, head_col} = {4'd4, 3'd3};
            8'h4C: {head_row, head_col} = {4'd4, 3'd4};
            8'h34: {head_row, head_col} = {4'd4, 3'd6};
            8'h36: {head_row, head_col} = {4'd4, 3'd7};
            8'h53: {head_row, head_col} = {4'd5, 3'd0};
            8'h46: {head_row, head_col} = {4'd5, 3'd1};
            8'h48: {head_row, head_col} = {4'd5, 3'd2};
            8'h4B: {head_row, head_col} = {4'd5, 3'd3};
            8'h3A: {head_row, head_col} = {4'd5, 3'd4};
            8'h35: {head_row, head_col} = {4'd5, 3'd6};
            8'h2A: {head_row, head_col} = {4'd5, 3'd7};
            8'h5A: {head_row, head_col} = {4'd6, 3'd0};
            8'h43: {head_row, head_col} = {4'd6, 3'd1};
            8'h42: {head_row, head_col} = {4'd6, 3'd2};
            8'h4D: {head_row, head_col} = {4'd6, 3'd3};
            8'h3B: {head_row, head_col} = {4'd6, 3'd4};
            8'h0D: {head_row, head_col} = {4'd6, 3'd5};
            8'h31: {head_row, head_col} = {4'd6, 3'd6};
            8'h33: {head_row, head_col} = {4'd6, 3'd7};
            8'h58: {head_row, head_col} = {4'd7, 3'd0};
            8'h56: {head_row, head_col} = {4'd7, 3'd1};
            8'h4E: {head_row, head_col} = {4'd7, 3'd2};
            8'h2C: {head_row, head_col} = {4'd7, 3'd3};
            8'h3F: {head_row, head_col} = {4'd7, 3'd4};
            8'h32: {head_row, head_col} = {4'd7, 3'd6};
            8'h2B: {head_row, head_col} = {4'd7, 3'd7};
            8'h40: {head_row, head_col} = {4'd8, 3'd1};
            8'h5D: {head_row, head_col} = {4'd8, 3'd2};
            8'h3E: {head_row, head_col} = {4'd8, 3'd4};
            8'h30: {head_row, head_col} = {4'd8, 3'd6};
            8'h2D: {head_row, head_col} = {4'd8, 3'd7};
            8'h5B: {head_row, head_col} = {4'd9, 3'd1};
            8'h20: {head_row, head_col} = {4'd9, 3'd2};
            8'h3C: {head_row, head_col} = {4'd9, 3'd3};
            8'h2E: {head_row, head_col} = {4'd9, 3'd6};
            8'h3D: {head_row, head_col} = {4'd9, 3'd7};
            default: head_valid = 1'b0;
        endcase
    end

    // Byte storage; entries are not cleared by reset because the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_data;
        end
    end

    // FIFO pointers, occupancy and the dropped-byte pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= uart_strobe && fifo_full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Next-state logic: pop and decode in IDLE, then count scan ticks through PRESS and GAP.
    always_comb begin
        state_n    = state;
        scan_cnt_n = scan_cnt;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                scan_cnt_n = 4'd0;
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_valid) begin
                        load    = 1'b1;
                        state_n = PRESS;
                    end
                end
            end
            PRESS: begin
                if (tick) begin
                    if (scan_cnt == HOLD_LAST) begin
                        state_n    = GAP;
                        scan_cnt_n = 4'd0;
                    end else begin
                        scan_cnt_n = scan_cnt + 4'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (scan_cnt == GAP_LAST) begin
                        state_n    = IDLE;
                        scan_cnt_n = 4'd0;
                    end else begin
                        scan_cnt_n = scan_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                scan_cnt_n = 4'd0;
            end
        endcase
    end

    // State register plus the latched key position of the press in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            scan_cnt <= 4'd0;
            key_row  <= 4'd0;
            key_col  <= 3'd0;
`ifdef PET_KEYQ_SHIFT_EN
            key_shift <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            scan_cnt <= scan_cnt_n;
            if (load) begin
                key_row <= head_row;
                key_col <= head_col;
`ifdef PET_KEYQ_SHIFT_EN
                key_shift <= head_shift;
`endif
            end
        end
    end

    // Column pattern for the row being scanned right now; rows past NUM_ROWS never match.
    always_comb begin
        keyin_n = 8'hFF;
        if (state == PRESS && {1'b0, keyrow} < ROW_LIMIT) begin
            if (keyrow == key_row) begin
                keyin_n[key_col] = 1'b0;
            end
`ifdef PET_KEYQ_SHIFT_EN
            if (key_shift && keyrow == 4'd8) begin
                keyin_n[0] = 1'b0;
            end
`endif
        end
    end

    // Register the scanned row (for tick detection) and the column bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            keyrow_q <= 4'd0;
            keyin    <= 8'hFF;
        end else begin
            keyrow_q <= keyrow;
            keyin    <= keyin_n;
        end
    end
endmodule

// File: tb/tb_pet_uart_keyq.sv
// tb_pet_uart_keyq: randomized scoreboard bench for pet_uart_keyq.
// A queue-based reference model tracks the FIFO and key timing; each accepted
// printable key pushes its expected press into a scoreboard that the keyin
// monitor pops when a press appears on the column bus.
module tb_pet_uart_keyq;
    localparam int HOLD  = 3;
    localparam int GAP   = 2;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keyrow;
    logic [7:0] keyin;
    logic [7:0] uart_data;
    logic       uart_strobe;
    logic [3:0] fifo_count;
    logic       fifo_full;
    logic       overflow;

    typedef struct {
        int row;
        int col;
        bit shift;
    } key_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned mq[$];
    key_t         expPress[$];
    int           mPhase = 0;
    int           mTicks = 0;
    logic [3:0]   mRowPrev = 4'd0;
    logic [3:0]   mSampRow = 4'd0;
    bit           mOvf = 0;
    bit           mResetEdge = 0;
    bit           started = 0;

    // Monitor state
    bit   inEp = 0;
    key_t cur;
    int   visits = 0;
    bit   lastOn = 0;

    pet_uart_keyq #(
        .FIFO_AW(AW), .HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .NUM_ROWS(10)
    ) dut (
        .clk(clk), .reset(reset), .keyrow(keyrow), .keyin(keyin),
        .uart_data(uart_data), .uart_strobe(uart_strobe),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keyboard matrix as the PET lays it out, eight columns per row; '~' marks keys
    // with no ASCII equivalent (shift, RVS, STOP, cursor keys).
    function automatic bit lookupKey(input byte unsigned ch, output int row, output int col,
                                     output bit shift);
        string m;
        byte unsigned c;
        m = {"!#%&(~~~", "\"$'\\)~~~", "QETUO~79", "WRYIP~8/", "ADGJL~46",
             "SFHK:~5*", "ZCBM;", "\015", "13", "XVN,?~2+", "~@]~>~0-", "~[ <~~.="};
        row   = 0;
        col   = 0;
        shift = 0;
        c     = ch;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            c = ch - 8'h20;
`ifdef PET_KEYQ_SHIFT_EN
            shift = 1;
`endif
        end
        if (c == 8'h7E) return 0;
        for (int i = 0; i < 80; i++) begin
            if (byte'(m[i]) == byte'(c)) begin
                row = i / 8;
                col = i % 8;
                return 1;
            end
        end
        return 0;
    endfunction

    // Column pattern a press of key k shows while row r is being scanned.
    function automatic logic [7:0] expMask(input key_t k, input logic [3:0] r);
        logic [7:0] v;
        v = 8'hFF;
        if (int'(r) == k.row) v[k.col] = 1'b0;
        if (k.shift && r == 4'd8) v[0] = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input byte unsigned b);
        uart_data   = b;
        uart_strobe = 1'b1;
        @(posedge clk);
        #1;
        uart_strobe = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (!(mPhase == 0 && mq.size() == 0 && !inEp && expPress.size() == 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    // The PET scanner: rows 0..9, 21 clocks each, changing just after the edge.
    initial begin
        keyrow = 4'd0;
        forever begin
            for (int r = 0; r < 10; r++) begin
                keyrow = 4'(r);
                repeat (21) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    end

    // Reference model: a byte queue, a press/gap phase and a scan-tick counter.
    always @(posedge clk) begin
        bit tick;
        bit pop;
        int r;
        int c;
        bit s;
        byte unsigned b;
        key_t k;
        mResetEdge = reset;
        mOvf       = 0;
        mSampRow   = keyrow;
        if (reset) begin
            started  = 1;
            mq.delete();
            expPress.delete();
            mPhase   = 0;
            mTicks   = 0;
            mRowPrev = 4'd0;
        end else begin
            tick     = (mRowPrev != 4'd0) && (keyrow == 4'd0);
            mRowPrev = keyrow;
            pop      = (mPhase == 0 && mq.size() != 0);
            if (pop) begin
                b = mq.pop_front();
                if (lookupKey(b, r, c, s)) begin
                    mPhase = 1;
                    mTicks = 0;
                end
            end else if (mPhase == 1 && tick) begin
                mTicks++;
                if (mTicks == HOLD) begin
                    mPhase = 2;
                    mTicks = 0;
                end
            end else if (mPhase == 2 && tick) begin
                mTicks++;
                if (mTicks == GAP) begin
                    mPhase = 0;
                    mTicks = 0;
                end
            end
            if (uart_strobe) begin
                if (mq.size() >= DEPTH) begin
                    mOvf = 1;
                end else begin
                    mq.push_back(uart_data);
                    if (lookupKey(uart_data, r, c, s)) begin
                        k.row   = r;
                        k.col   = c;
                        k.shift = s;
                        expPress.push_back(k);
                    end
                end
            end
        end
    end

    // Monitor: status outputs every cycle, and each press on keyin against the scoreboard.
    always @(negedge clk) begin
        logic [7:0] expv;
        if (started) begin
            checkOutput("fifo_count", int'(fifo_count), mq.size());
            checkOutput("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
            checkOutput("overflow", int'(overflow), int'(mOvf));
            if (mResetEdge) begin
                inEp = 0;
                checkOutput("reset_keyin", int'(keyin), 8'hFF);
            end else begin
                if (!inEp && keyin != 8'hFF) begin
                    if (expPress.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_press: keyin %02h on row %0d, required ff (t=%0t)",
                                 keyin, mSampRow, $time);
                    end else begin
                        cur    = expPress.pop_front();
                        inEp   = 1;
                        visits = 0;
                        lastOn = 0;
                    end
                end
                if (inEp) begin
                    if (int'(mSampRow) == cur.row && keyin == 8'hFF) begin
                        inEp = 0;
                        checkOutput("press_scans",
                                    (visits >= HOLD - 1 && visits <= HOLD + 1) ? HOLD : visits, HOLD);
                    end else begin
                        expv = expMask(cur, mSampRow);
                        checkOutput("keyin_press", int'(keyin), int'(expv));
                        if (int'(mSampRow) == cur.row) begin
                            if (!lastOn) visits++;
                            lastOn = 1;
                        end else begin
                            lastOn = 0;
                        end
                    end
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        byte unsigned b;
        int rr;
        int cc;
        bit ss;
        int n;
        reset       = 1'b1;
        uart_strobe = 1'b0;
        uart_data   = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_keyin_out", int'(keyin), 8'hFF);
        checkOutput("reset_count", int'(fifo_count), 0);
        checkOutput("reset_full", int'(fifo_full), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;

        $display("[TB] test 1: RETURN");
        applyStimulus(8'h0D);
        waitIdle("t1_return", 3000);

        $display("[TB] test 2: 'A'");
        applyStimulus(8'h41);
        waitIdle("t2_a", 3000);

        $display("[TB] test 3: ten back-to-back strobes");
        for (int i = 0; i < 10; i++) begin
            do b = 8'($urandom_range(32, 126)); while (!lookupKey(b, rr, cc, ss));
            applyStimulus(b);
        end
        @(negedge clk);
        checkOutput("t3_overflow", int'(overflow), 1);
        checkOutput("t3_full", int'(fifo_full), 1);
        checkOutput("t3_count", int'(fifo_count), 8);
        @(posedge clk);
        #1;
        waitIdle("t3_replay", 16000);

        $display("[TB] test 4: lower-case 'a'");
        applyStimulus(8'h61);
        waitIdle("t4_lower", 3000);

        $display("[TB] test 5: unmapped 0x01 then 'A'");
        applyStimulus(8'h01);
        applyStimulus(8'h41);
        waitIdle("t5_skip", 3000);

        $display("[TB] test 6: random bytes with random gaps");
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = 8'($urandom_range(32, 122));
            applyStimulus(b);
            repeat ($urandom_range(0, 300)) begin
                @(posedge clk);
                #1;
            end
        end
        waitIdle("t6_random", 20000);

        $display("[TB] test 7: reset during a press");
        applyStimulus(8'h0D);
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        n = 0;
        while (mPhase != 1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t7_press_started", int'(mPhase == 1), 1);
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t7_count_before", int'(fifo_count), 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t7_keyin_after", int'(keyin), 8'hFF);
        checkOutput("t7_count_after", int'(fifo_count), 0);
        repeat (600) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t7_count_late", int'(fifo_count), 0);
        checkOutput("t7_keyin_late", int'(keyin), 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
